// File: rtl/acquire_trigger_pkg.sv
// Shared types and default sizing for the acquire_trigger capture controller.
package acquire_trigger_pkg;

  localparam int unsigned DEFAULT_RADIOS    = 24;
  localparam int unsigned DEFAULT_FRAME_LEN = 1024;
  localparam int unsigned DEFAULT_FBITS     = 16;
  localparam int unsigned DEFAULT_CBITS     = 32;

  // Capture controller states; encodings are fixed for register-bank visibility.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/acq_frame_counter.sv
// Sample-in-frame and frame counters for acquire_trigger; flags frame end and capture end.
module acq_frame_counter
  import acquire_trigger_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int unsigned FBITS     = DEFAULT_FBITS
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [FBITS-1:0] frames_i,
  output logic             last_c_o,
  output logic             final_c_o
);

  localparam int unsigned SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SW-1:0] SAMPLE_MAX = SW'(FRAME_LEN - 1);

  logic [SW-1:0]    sample_q, sample_d;
  logic [FBITS-1:0] frame_q, frame_d;

  // frame_q counts completed frames, so the final frame is frame_q == frames_i-1
  assign last_c_o  = (sample_q == SAMPLE_MAX);
  assign final_c_o = last_c_o && ((frame_q + FBITS'(1)) == frames_i);

  // Advance within the frame; wrap and bump the frame count on the last sample.
  always_comb begin
    sample_d = sample_q;
    frame_d  = frame_q;
    if (clear_i) begin
      sample_d = '0;
      frame_d  = '0;
    end else if (tick_i) begin
      if (last_c_o) begin
        sample_d = '0;
        frame_d  = frame_q + FBITS'(1);
      end else begin
        sample_d = sample_q + SW'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sample_q <= '0;
      frame_q  <= '0;
    end else begin
      sample_q <= sample_d;
      frame_q  <= frame_d;
    end
  end

endmodule

// File: rtl/acquire_trigger.sv
// Capture controller: gates the I/Q stream into N frames of FRAME_LEN samples.
// Optional ramp test pattern source enabled by defining ACQUIRE_TESTPAT_EN.
module acquire_trigger
  import acquire_trigger_pkg::*;
#(
  parameter int unsigned RADIOS    = DEFAULT_RADIOS,
  parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int unsigned FBITS     = DEFAULT_FBITS,
  parameter int unsigned CBITS     = DEFAULT_CBITS
) (
  input  logic              sig_clock,
  input  logic              sig_resetn,
  input  logic              strobe_i,
  input  logic [RADIOS-1:0] idata_i,
  input  logic [RADIOS-1:0] qdata_i,
  input  logic              start_i,
  input  logic [FBITS-1:0]  frames_i,
  input  logic              sync_en_i,
  input  logic              sync_i,
  input  logic              abort_i,
`ifdef ACQUIRE_TESTPAT_EN
  input  logic              testpat_i,
`endif
  output logic              sig_valid_o,
  output logic              sig_last_o,
  output logic [RADIOS-1:0] sig_idata_o,
  output logic [RADIOS-1:0] sig_qdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CBITS-1:0]  count_o
);

  state_e            state_q, state_d;
  logic [FBITS-1:0]  frames_q, frames_d;
  logic              sync_en_q, sync_en_d;
  logic [CBITS-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [RADIOS-1:0] idata_q, idata_d;
  logic [RADIOS-1:0] qdata_q, qdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fc_clear, fc_tick, fc_last, fc_final;
`ifdef ACQUIRE_TESTPAT_EN
  logic              testpat_q, testpat_d;
  logic [RADIOS-1:0] ramp;
`endif

  acq_frame_counter #(
    .FRAME_LEN (FRAME_LEN),
    .FBITS     (FBITS)
  ) u_frame_counter (
    .clk_i     (sig_clock),
    .rst_n_i   (sig_resetn),
    .clear_i   (fc_clear),
    .tick_i    (fc_tick),
    .frames_i  (frames_q),
    .last_c_o  (fc_last),
    .final_c_o (fc_final)
  );

`ifdef ACQUIRE_TESTPAT_EN
  // Ramp value is the emitted-sample count before this sample is counted.
  assign ramp = RADIOS'(count_q);
`endif

  // Next-state, counters and output payload; abort has priority over capture.
  always_comb begin
    state_d   = state_q;
    frames_d  = frames_q;
    sync_en_d = sync_en_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    idata_d   = idata_q;
    qdata_d   = qdata_q;
    done_d    = 1'b0;
    fc_clear  = 1'b0;
    fc_tick   = 1'b0;
`ifdef ACQUIRE_TESTPAT_EN
    testpat_d = testpat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && (frames_i != '0)) begin
          frames_d  = frames_i;
          sync_en_d = sync_en_i;
          count_d   = '0;
          fc_clear  = 1'b1;
`ifdef ACQUIRE_TESTPAT_EN
          testpat_d = testpat_i;
`endif
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (!sync_en_q || sync_i) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (strobe_i) begin
          valid_d = 1'b1;
          last_d  = fc_last;
          fc_tick = 1'b1;
          count_d = count_q + CBITS'(1);
`ifdef ACQUIRE_TESTPAT_EN
          if (testpat_q) begin
            idata_d = ramp;
            qdata_d = ~ramp;
          end else begin
            idata_d = idata_i;
            qdata_d = qdata_i;
          end
`else
          idata_d = idata_i;
          qdata_d = qdata_i;
`endif
          if (fc_final) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sig_clock) begin
    if (!sig_resetn) begin
      state_q   <= ST_IDLE;
      frames_q  <= '0;
      sync_en_q <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      idata_q   <= '0;
      qdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ACQUIRE_TESTPAT_EN
      testpat_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      frames_q  <= frames_d;
      sync_en_q <= sync_en_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      idata_q   <= idata_d;
      qdata_q   <= qdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ACQUIRE_TESTPAT_EN
      testpat_q <= testpat_d;
`endif
    end
  end

  assign sig_valid_o = valid_q;
  assign sig_last_o  = last_q;
  assign sig_idata_o = idata_q;
  assign sig_qdata_o = qdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_acquire_trigger.sv
// Self-checking bench for acquire_trigger: capture-session reference model plus directed scenarios.
module tb_acquire_trigger;

  localparam int unsigned RADIOS    = 24;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned FBITS     = 16;
  localparam int unsigned CBITS     = 32;
`ifdef ACQUIRE_TESTPAT_EN
  localparam bit TP_ON = 1'b1;
`else
  localparam bit TP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              strobe;
  logic [RADIOS-1:0] idata, qdata;
  logic              start;
  logic [FBITS-1:0]  frames;
  logic              sync_en, sync, abort, testpat;
  logic              sig_valid_o, sig_last_o, busy_o, done_o;
  logic [RADIOS-1:0] sig_idata_o, sig_qdata_o;
  logic [CBITS-1:0]  count_o;

  always #5 clk = ~clk;

  acquire_trigger #(
    .RADIOS(RADIOS), .FRAME_LEN(FRAME_LEN), .FBITS(FBITS), .CBITS(CBITS)
  ) dut (
    .sig_clock   (clk),
    .sig_resetn  (rstn),
    .strobe_i    (strobe),
    .idata_i     (idata),
    .qdata_i     (qdata),
    .start_i     (start),
    .frames_i    (frames),
    .sync_en_i   (sync_en),
    .sync_i      (sync),
    .abort_i     (abort),
`ifdef ACQUIRE_TESTPAT_EN
    .testpat_i   (testpat),
`endif
    .sig_valid_o (sig_valid_o),
    .sig_last_o  (sig_last_o),
    .sig_idata_o (sig_idata_o),
    .sig_qdata_o (sig_qdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .count_o     (count_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a capture session is a sample budget of frames*FRAME_LEN.
  localparam int P_IDLE = 0, P_WAIT = 1, P_RUN = 2, P_FIN = 3;
  int                m_phase = P_IDLE;
  longint            m_n = 0, m_target = 0;
  bit                m_need_sync = 1'b0, m_tp = 1'b0;
  logic              e_valid = 1'b0, e_last = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  logic [CBITS-1:0]  e_count = '0;
  logic [RADIOS-1:0] e_i = '0, e_q = '0, rv;

  always @(posedge clk) begin
    if (!rstn) begin
      m_phase = P_IDLE;
      e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      e_count = '0; e_i = '0; e_q = '0;
    end else begin
      e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0;
      case (m_phase)
        P_IDLE: if (start && frames != 0) begin
          m_target    = longint'(frames) * FRAME_LEN;
          m_need_sync = sync_en;
          m_tp        = TP_ON && testpat;
          m_n         = 0;
          e_count     = '0;
          m_phase     = P_WAIT;
        end
        P_WAIT: begin
          if (abort) m_phase = P_IDLE;
          else if (!m_need_sync || sync) m_phase = P_RUN;
        end
        P_RUN: begin
          if (abort) m_phase = P_IDLE;
          else if (strobe) begin
            rv      = RADIOS'(e_count);
            e_valid = 1'b1;
            e_i     = m_tp ? rv : idata;
            e_q     = m_tp ? ~rv : qdata;
            e_count = e_count + CBITS'(1);
            m_n++;
            e_last  = (m_n % FRAME_LEN) == 0;
            if (m_n == m_target) m_phase = P_FIN;
          end
        end
        default: begin
          e_done  = 1'b1;
          m_phase = P_IDLE;
        end
      endcase
      e_busy = (m_phase == P_WAIT) || (m_phase == P_RUN);
    end
  end

  // Stimulus data source: strobe patterns selected by smode.
  int smode = 0;
  int ph = 0;
  always @(negedge clk) begin
    idata = RADIOS'($urandom);
    qdata = RADIOS'($urandom);
    case (smode)
      0: strobe = 1'b0;
      1: strobe = 1'b1;
      2: begin strobe = (ph == 0); ph = (ph + 1) % 3; end
      default: strobe = ($urandom % 4) != 0;
    endcase
  end

  // Run-time statistics gathered from the DUT outputs, checked against literals.
  int cyc = 0, vcount = 0, ndone = 0, first_v = -1, last_v = -1, done_cyc = -1;
  int start_cyc = 0, sync_cyc = 0;
  logic [31:0] lastmask = '0;

  task automatic compare_loop();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      check("valid", sig_valid_o, e_valid);
      check("last",  sig_last_o,  e_last);
      check("done",  done_o,      e_done);
      check("busy",  busy_o,      e_busy);
      check("count", count_o,     e_count);
      check("idata", sig_idata_o, e_i);
      check("qdata", sig_qdata_o, e_q);
      if (sig_valid_o === 1'b1) begin
        vcount++;
        if (vcount == 1) first_v = cyc;
        last_v = cyc;
        if (sig_last_o === 1'b1 && vcount <= 32) lastmask[vcount-1] = 1'b1;
      end
      if (done_o === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic clear_stats();
    vcount = 0; ndone = 0; first_v = -1; last_v = -1; done_cyc = -1; lastmask = '0;
  endtask

  task automatic do_start(input int f, input bit se, input bit tp);
    @(negedge clk);
    start = 1'b1; frames = FBITS'(f); sync_en = se; testpat = tp;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0; frames = FBITS'($urandom); sync_en = 1'b0; testpat = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (ndone == 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", ndone, 1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; frames = '0; sync_en = 1'b0; sync = 1'b0;
    abort = 1'b0; testpat = 1'b0; strobe = 1'b0; idata = '0; qdata = '0;
    fork
      compare_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_valid", sig_valid_o, 0);
    check("rst_count", count_o, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Two frames, continuous strobe
    clear_stats();
    smode = 1;
    do_start(2, 1'b0, 1'b0);
    wait_done(40);
    check("s1_nvalid", vcount, 8);
    check("s1_lastmask", lastmask, 32'h88);
    check("s1_latency", first_v - start_cyc, 2);
    check("s1_done_after_last", done_cyc - last_v, 1);
    check("s1_count", count_o, 8);
    smode = 0;
    repeat (3) @(negedge clk);

    // One frame at 1-in-3 strobe duty
    clear_stats();
    smode = 2;
    do_start(1, 1'b0, 1'b0);
    wait_done(60);
    check("s2_nvalid", vcount, 4);
    check("s2_lastmask", lastmask, 32'h8);
    check("s2_span", last_v - first_v, 9);
    check("s2_count", count_o, 4);
    smode = 0;
    repeat (3) @(negedge clk);

    // Sync-aligned capture
    clear_stats();
    smode = 3;
    do_start(1, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    check("s3_busy_in_arm", busy_o, 1);
    check("s3_no_valid_before_sync", vcount, 0);
    sync = 1'b1;
    sync_cyc = cyc + 1;
    @(negedge clk);
    sync = 1'b0;
    wait_done(100);
    check("s3_first_after_sync", (first_v >= sync_cyc + 1), 1);
    check("s3_count", count_o, 4);
    smode = 0;
    repeat (3) @(negedge clk);

    // Abort on third sample of frame two, with a simultaneous start
    clear_stats();
    smode = 1;
    do_start(2, 1'b0, 1'b0);
    for (int k = 0; k < 30 && !(m_n == 6 && m_phase == P_RUN); k++) @(negedge clk);
    abort = 1'b1; start = 1'b1; frames = 16'd3;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    check("s4_count", count_o, 6);
    check("s4_nvalid", vcount, 6);
    check("s4_no_done", ndone, 0);
    check("s4_lastmask", lastmask, 32'h8);
    check("s4_busy", busy_o, 0);
    smode = 0;
    repeat (2) @(negedge clk);

    // Reset mid-capture, then a zero-frame start
    smode = 1;
    do_start(3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("s5_valid", sig_valid_o, 0);
    check("s5_count", count_o, 0);
    check("s5_busy", busy_o, 0);
    check("s5_idata", sig_idata_o, 0);
    rstn = 1'b1;
    clear_stats();
    do_start(0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("s5_zero_busy", busy_o, 0);
    check("s5_zero_nvalid", vcount, 0);
    smode = 0;
    repeat (2) @(negedge clk);

`ifdef ACQUIRE_TESTPAT_EN
    // Ramp test pattern, same framing as the two-frame run
    begin
      int idx = 0;
      clear_stats();
      smode = 1;
      do_start(2, 1'b0, 1'b1);
      for (int k = 0; k < 30 && idx < 8; k++) begin
        @(negedge clk);
        if (sig_valid_o === 1'b1) begin
          rv = RADIOS'(idx);
          check("tp_ramp_i", sig_idata_o, rv);
          check("tp_ramp_q", sig_qdata_o, ~rv);
          idx++;
        end
      end
      wait_done(10);
      check("tp_lastmask", lastmask, 32'h88);
      check("tp_count", count_o, 8);
      smode = 0;
      repeat (3) @(negedge clk);
    end
`endif

    // Randomized traffic against the model
    smode = 3;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start   = ($urandom % 16) == 0;
      frames  = FBITS'($urandom % 4);
      sync_en = $urandom % 2;
      sync    = ($urandom % 12) == 0;
      abort   = ($urandom % 120) == 0;
      testpat = $urandom % 2;
      rstn    = ($urandom % 800) != 0;
    end
    @(negedge clk);
    start = 1'b0; sync = 1'b0; abort = 1'b0; rstn = 1'b1; smode = 0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
